// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode legality check for alu_seq.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_ADC = 4'd8;
   localparam logic [3:0] OP_SBB = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DONE    = 2'd2
   } state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle.
// The multiplier sits in the low half of the accumulator and is consumed
// from bit 0 as the accumulator shifts right; after WIDTH steps the
// accumulator holds the full 2*WIDTH product.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     sum;

   // Load on start, otherwise one add-and-shift step per busy cycle.
   always_comb begin
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      if (start_i) begin
         acc_d   = {{WIDTH{1'b0}}, b_i};
         mcand_d = a_i;
         cnt_d   = '0;
         busy_d  = 1'b1;
      end else if (busy_q) begin
         acc_d = {sum, acc_q[WIDTH-1:1]};
         if (cnt_q == CW'(WIDTH-1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Multiplier state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mcand_q <= '0;
         acc_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, stored carry for ADC/SBB
// chains and a multi-cycle multiplier.
//
//   state   | meaning
//   IDLE    | no result held, ready for an operation
//   MUL_RUN | multiplier iterating, input side stalled
//   DONE    | result registers valid, held until the consumer takes them
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opCode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] Out_hi,
   output logic             Carry_out,
   output logic             C_flag,
   output logic             Zero,
   output logic             Err
);

   localparam int SHW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic               accept, xfer, load_alu, mul_start;
   logic               mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [WIDTH-1:0]   out_q, out_hi_q;
   logic               cout_q, cflag_q, zero_q, err_q, carry_reg_q;

   logic               cin, bin;
   logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
   logic [SHW-1:0]     sh;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_cout, alu_cflag, alu_err, alu_upd;

   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;
   assign mul_start = accept && (opCode == OP_MUL);
   assign load_alu  = accept && (opCode != OP_MUL);

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (A),
      .b_i       (B),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: accepts may chain straight from DONE when the result drains.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (opCode == OP_MUL) state_d = MUL_RUN;
               else                  state_d = DONE;
            end
         end
         MUL_RUN: begin
            if (mul_done) state_d = DONE;
         end
         DONE: begin
            if (xfer) begin
               if (!accept)                state_d = IDLE;
               else if (opCode == OP_MUL)  state_d = MUL_RUN;
               else                        state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs; in_ready passes out_ready through in DONE.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: in_ready = rst_n && !mul_busy;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = rst_n && out_ready && !mul_busy;
         end
         default: ;
      endcase
   end

   // Single-cycle datapath; ADC/SBB fold the stored carry into add/sub.
   always_comb begin
      cin   = (opCode == OP_ADC) ? carry_reg_q : 1'b0;
      bin   = (opCode == OP_SBB) ? carry_reg_q : 1'b0;
      sh    = B[SHW-1:0];
      add_w = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
      sub_w = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, bin};
      shl_w = {1'b0, A} << sh;
      shr_w = {A, 1'b0} >> sh;
      alu_res   = '0;
      alu_cout  = 1'b0;
      alu_cflag = 1'b0;
      alu_upd   = 1'b0;
      alu_err   = !is_legal_op(opCode);
      case (opCode)
         OP_ADD, OP_ADC: begin
            alu_res  = add_w[WIDTH-1:0];
            alu_cout = add_w[WIDTH];
            alu_upd  = 1'b1;
         end
         OP_SUB, OP_SBB: begin
            alu_res  = sub_w[WIDTH-1:0];
            alu_cout = sub_w[WIDTH];
            alu_upd  = 1'b1;
         end
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_CMP: begin
            alu_cflag = (A > B);
            alu_cout  = (A < B);
         end
         OP_SHL: begin
            alu_res  = shl_w[WIDTH-1:0];
            alu_cout = shl_w[WIDTH];
            alu_upd  = 1'b1;
         end
         OP_SHR: begin
            alu_res  = shr_w[WIDTH:1];
            alu_cout = shr_w[0];
            alu_upd  = 1'b1;
         end
         default: ;
      endcase
   end

   // Result/flag registers load on a single-cycle accept or multiplier finish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_hi_q    <= '0;
         cout_q      <= 1'b0;
         cflag_q     <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         carry_reg_q <= 1'b0;
      end else if (load_alu) begin
         out_q    <= alu_res;
         out_hi_q <= '0;
         cout_q   <= alu_cout;
         cflag_q  <= alu_cflag;
         zero_q   <= (alu_res == '0);
         err_q    <= alu_err;
         if (alu_upd) carry_reg_q <= alu_cout;
      end else if ((state_q == MUL_RUN) && mul_done) begin
         out_q       <= mul_prod[WIDTH-1:0];
         out_hi_q    <= mul_prod[2*WIDTH-1:WIDTH];
         cout_q      <= |mul_prod[2*WIDTH-1:WIDTH];
         cflag_q     <= 1'b0;
         zero_q      <= (mul_prod == '0);
         err_q       <= 1'b0;
         carry_reg_q <= |mul_prod[2*WIDTH-1:WIDTH];
      end
   end

   assign Out       = out_q;
   assign Out_hi    = out_hi_q;
   assign Carry_out = cout_q;
   assign C_flag    = cflag_q;
   assign Zero      = zero_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic [3:0] opCode = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] Out, Out_hi;
   logic       Carry_out, C_flag, Zero, Err;

   int checks = 0;
   int failures = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .opCode    (opCode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Out       (Out),
      .Out_hi    (Out_hi),
      .Carry_out (Carry_out),
      .C_flag    (C_flag),
      .Zero      (Zero),
      .Err       (Err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operation for a single edge; caller ensures in_ready is high.
   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      opCode   = op;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      A        = 8'hA5;
      B        = 8'h5A;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({out_valid, Out, Out_hi, Carry_out, C_flag, Zero, Err} !== 21'd0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b out=%h hi=%h c=%b cf=%b z=%b e=%b, need all 0",
                  out_valid, Out, Out_hi, Carry_out, C_flag, Zero, Err);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b need 1", in_ready);
      end
   endtask

   task automatic test_add_adc();
      send(4'd0, 8'hFF, 8'h01);
      checks++;
      if ({out_valid, Out, Carry_out, Zero, Err} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL add_ff_01: got v=%b out=%h c=%b z=%b e=%b need v=1 out=00 c=1 z=1 e=0",
                  out_valid, Out, Carry_out, Zero, Err);
      end
      send(4'd8, 8'h00, 8'h00);
      checks++;
      if ({out_valid, Out, Carry_out, Zero} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL adc_carry_in: got v=%b out=%h c=%b z=%b need v=1 out=01 c=0 z=0",
                  out_valid, Out, Carry_out, Zero);
      end
   endtask

   task automatic test_sub_cmp();
      send(4'd1, 8'h01, 8'h02);
      checks++;
      if ({Out, Carry_out, C_flag} !== {8'hFF, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sub_borrow: got out=%h c=%b cf=%b need out=FF c=1 cf=0", Out, Carry_out, C_flag);
      end
      send(4'd9, 8'h05, 8'h01);
      checks++;
      if ({Out, Carry_out} !== {8'h03, 1'b0}) begin
         failures++;
         $display("FAIL sbb_borrow_in: got out=%h c=%b need out=03 c=0", Out, Carry_out);
      end
      send(4'd5, 8'h0D, 8'h06);
      checks++;
      if ({Out, C_flag, Carry_out, Zero} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL cmp_gt: got out=%h cf=%b c=%b z=%b need out=00 cf=1 c=0 z=1", Out, C_flag, Carry_out, Zero);
      end
      send(4'd5, 8'h06, 8'h0D);
      checks++;
      if ({Out, C_flag, Carry_out} !== {8'h00, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL cmp_lt: got out=%h cf=%b c=%b need out=00 cf=0 c=1", Out, C_flag, Carry_out);
      end
   endtask

   task automatic test_mul();
      int bad;
      int n;
      send(4'd10, 8'h0D, 8'h06);
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mul_stall: %0d of 9 cycles had out_valid or in_ready high, need 0", bad);
      end
      checks++;
      if ({out_valid, Out, Out_hi, Carry_out, Zero} !== {1'b1, 8'h4E, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL mul_0d_06: got v=%b out=%h hi=%h c=%b z=%b need v=1 out=4E hi=00 c=0 z=0",
                  out_valid, Out, Out_hi, Carry_out, Zero);
      end
      send(4'd10, 8'hFF, 8'hFF);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if ({out_valid, Out, Out_hi, Carry_out} !== {1'b1, 8'h01, 8'hFE, 1'b1}) begin
         failures++;
         $display("FAIL mul_ff_ff: got v=%b out=%h hi=%h c=%b need v=1 out=01 hi=FE c=1",
                  out_valid, Out, Out_hi, Carry_out);
      end
   endtask

   task automatic test_shift();
      send(4'd6, 8'h0D, 8'h03);
      checks++;
      if ({Out, Out_hi, Carry_out} !== {8'h68, 8'h00, 1'b0}) begin
         failures++;
         $display("FAIL shl_3: got out=%h hi=%h c=%b need out=68 hi=00 c=0", Out, Out_hi, Carry_out);
      end
      send(4'd6, 8'h81, 8'h01);
      checks++;
      if ({Out, Carry_out} !== {8'h02, 1'b1}) begin
         failures++;
         $display("FAIL shl_msb_out: got out=%h c=%b need out=02 c=1", Out, Carry_out);
      end
      send(4'd7, 8'h0D, 8'h01);
      checks++;
      if ({Out, Carry_out} !== {8'h06, 1'b1}) begin
         failures++;
         $display("FAIL shr_1: got out=%h c=%b need out=06 c=1", Out, Carry_out);
      end
      send(4'd6, 8'h8D, 8'h08);
      checks++;
      if ({Out, Carry_out} !== {8'h8D, 1'b0}) begin
         failures++;
         $display("FAIL shl_zero_amount: got out=%h c=%b need out=8D c=0", Out, Carry_out);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      int runs;
      send(4'd2, 8'h0F, 8'h3C);
      out_ready = 1'b0;
      #1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if ({out_valid, in_ready, Out, Carry_out, Zero, Err} !== {1'b1, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0}) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_stable: %0d of 3 stalled cycles changed, need out=0C held and in_ready=0", bad);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_passthrough: got in_ready=%b need 1", in_ready);
      end
      send(4'd4, 8'h0D, 8'h06);
      checks++;
      if ({out_valid, Out} !== {1'b1, 8'h0B}) begin
         failures++;
         $display("FAIL xfer_and_accept: got v=%b out=%h need v=1 out=0B", out_valid, Out);
      end
      bad  = 0;
      runs = 0;
      for (int i = 0; i < 10; i++) begin
         logic [7:0] a;
         a = 8'(i * 3);
         if (in_ready !== 1'b1) bad++;
         opCode   = 4'd0;
         A        = a;
         B        = 8'h05;
         in_valid = 1'b1;
         step();
         if (out_valid === 1'b1 && Out === 8'(a + 8'h05)) runs++;
      end
      in_valid = 1'b0;
      checks++;
      if (runs != 10 || bad != 0) begin
         failures++;
         $display("FAIL stream_10: got %0d correct valid cycles and %0d not-ready cycles, need 10 and 0", runs, bad);
      end
   endtask

   task automatic test_reset_mid_mul();
      send(4'd0, 8'hFF, 8'h01);
      send(4'd10, 8'h0D, 8'h06);
      step();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, Out, Out_hi, Carry_out, C_flag, Zero, Err} !== 21'd0) begin
         failures++;
         $display("FAIL async_reset: got v=%b out=%h hi=%h c=%b cf=%b z=%b e=%b need all 0",
                  out_valid, Out, Out_hi, Carry_out, C_flag, Zero, Err);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL post_reset_idle: got in_ready=%b v=%b need 1 0", in_ready, out_valid);
      end
      send(4'd8, 8'h00, 8'h00);
      checks++;
      if ({out_valid, Out, Carry_out, Zero} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL carry_cleared: got v=%b out=%h c=%b z=%b need v=1 out=00 c=0 z=1",
                  out_valid, Out, Carry_out, Zero);
      end
   endtask

   task automatic test_illegal();
      send(4'd0, 8'hFF, 8'h01);
      send(4'hC, 8'h12, 8'h34);
      checks++;
      if ({out_valid, Err, Out, Out_hi, Carry_out, Zero} !== {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL illegal_op: got v=%b e=%b out=%h hi=%h c=%b z=%b need v=1 e=1 out=00 hi=00 c=0 z=1",
                  out_valid, Err, Out, Out_hi, Carry_out, Zero);
      end
      send(4'd8, 8'h00, 8'h00);
      checks++;
      if ({Out, Err, Carry_out} !== {8'h01, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL carry_kept_by_illegal: got out=%h e=%b c=%b need out=01 e=0 c=0", Out, Err, Carry_out);
      end
   endtask

   initial begin
      test_reset();
      test_add_adc();
      test_sub_cmp();
      test_mul();
      test_shift();
      test_backpressure();
      test_reset_mid_mul();
      test_illegal();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
